// File: rtl/dtree_node_evaluator_if.sv
// Bundles the feature-vector input, node-memory read port and classification output.
// Trace signals (out_path, out_depth) exist only when DTREE_TRACE_EN is defined.
interface dtree_node_evaluator_if #(
    parameter int DEPTH    = 24,
    parameter int ADDR_W   = 3,
    parameter int FEATURES = 3,
    parameter int FEAT_W   = 8
);
    logic                       in_valid;
    logic                       in_ready;
    logic [FEATURES*FEAT_W-1:0] in_features;
    logic                       mem_ce;
    logic                       mem_we;
    logic [ADDR_W-1:0]          mem_a;
    logic [DEPTH-1:0]           mem_q;
    logic                       out_valid;
    logic                       out_ready;
    logic [ADDR_W:0]            out_class;
    logic                       out_err;
`ifdef DTREE_TRACE_EN
    logic [ADDR_W:0]            out_path;
    logic [ADDR_W:0]            out_depth;
`endif

    // master: surrounding system (feature source, memory, classifier sink); slave: the evaluator
    modport master (
        output in_valid, in_features, mem_q, out_ready,
        input  in_ready, mem_ce, mem_we, mem_a, out_valid, out_class, out_err
`ifdef DTREE_TRACE_EN
        , input out_path, out_depth
`endif
    );

    modport slave (
        input  in_valid, in_features, mem_q, out_ready,
        output in_ready, mem_ce, mem_we, mem_a, out_valid, out_class, out_err
`ifdef DTREE_TRACE_EN
        , output out_path, out_depth
`endif
    );
endinterface

// File: rtl/dtree_node_evaluator.sv
// Walks a heap-ordered oblique decision tree, one node read per FETCH/EVAL pair.
// Optional DTREE_TRACE_EN adds out_path (per-level direction) and out_depth (nodes evaluated).
module dtree_node_evaluator #(
    parameter int DEPTH           = 24,
    parameter int WORDS           = 8,
    parameter int FEATURES        = 3,
    parameter int COEFF_BIT_DEPTH = 4,
    parameter int BIAS_BIT_DEPTH  = 10,
    parameter int FEAT_W          = 8
) (
    input logic                   clk,
    input logic                   reset,
    dtree_node_evaluator_if.slave bus
);
    localparam int ADDR_W  = $clog2(WORDS);
    localparam int ACC_W   = FEAT_W + COEFF_BIT_DEPTH + $clog2(FEATURES) + 2;
    localparam int COEF_LSB = BIAS_BIT_DEPTH;
    localparam int OH_LSB  = BIAS_BIT_DEPTH + (FEATURES - 1) * COEFF_BIT_DEPTH;
    localparam int LP_BIT  = OH_LSB + FEATURES;
    localparam int RP_BIT  = LP_BIT + 1;

    typedef enum logic [1:0] {IDLE, FETCH, EVAL, DONE} state_t;

    state_t state, state_next;

    logic signed [FEAT_W-1:0]          feat_q [FEATURES];
    logic [ADDR_W-1:0]                 node;
    logic [ADDR_W:0]                   cls_q;
    logic                              err_q;

    logic [FEATURES-1:0]               onehot;
    logic                              malformed;
    int unsigned                       p_idx;
    logic signed [BIAS_BIT_DEPTH-1:0]  bias_f;
    logic signed [COEFF_BIT_DEPTH-1:0] cf;
    logic signed [FEAT_W-1:0]          fm;
    logic signed [ACC_W-1:0]           acc;
    logic                              dir;
    logic                              present;
    logic [ADDR_W+1:0]                 child;
    logic                              overflow;
    logic                              unused_reserved;

    assign unused_reserved = ^bus.mem_q[DEPTH-1:RP_BIT+1];

    // Node evaluation on the word returned by the previous FETCH
    always_comb begin
        onehot    = bus.mem_q[OH_LSB +: FEATURES];
        malformed = !$onehot(onehot);
        bias_f    = bus.mem_q[BIAS_BIT_DEPTH-1:0];
        p_idx     = 0;
        for (int unsigned i = 0; i < FEATURES; i++)
            if (onehot[i]) p_idx = i;
        acc = ACC_W'(bias_f);
        for (int unsigned i = 0; i < FEATURES; i++)
            if (i == p_idx) acc = acc + ACC_W'(feat_q[i]);
        cf = '0;
        fm = '0;
        // coefficients skip over the one-hot selected feature
        for (int unsigned k = 0; k < FEATURES - 1; k++) begin
            cf  = bus.mem_q[COEF_LSB + k*COEFF_BIT_DEPTH +: COEFF_BIT_DEPTH];
            fm  = (k < p_idx) ? feat_q[k] : feat_q[k+1];
            acc = acc + ACC_W'(cf) * ACC_W'(fm);
        end
        dir      = ~acc[ACC_W-1];
        present  = dir ? bus.mem_q[RP_BIT] : bus.mem_q[LP_BIT];
        child    = {1'b0, node, 1'b0} + (ADDR_W+2)'(1) + (ADDR_W+2)'(dir);
        overflow = child >= (ADDR_W+2)'(WORDS);
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next    = state;
        bus.in_ready  = 1'b0;
        bus.mem_ce    = 1'b0;
        bus.mem_a     = '0;
        bus.out_valid = 1'b0;
        case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) state_next = FETCH;
            end
            FETCH: begin
                bus.mem_ce = 1'b1;
                bus.mem_a  = node;
                state_next = EVAL;
            end
            EVAL: begin
                if (!malformed && present && !overflow) state_next = FETCH;
                else                                     state_next = DONE;
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        // reset masks the handshake and memory strobes within the same cycle
        if (reset) begin
            bus.in_ready  = 1'b0;
            bus.mem_ce    = 1'b0;
            bus.mem_a     = '0;
            bus.out_valid = 1'b0;
        end
    end

    assign bus.mem_we    = 1'b0;
    assign bus.out_class = cls_q;
    assign bus.out_err   = err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            node  <= '0;
            cls_q <= '0;
            err_q <= 1'b0;
            for (int unsigned i = 0; i < FEATURES; i++) feat_q[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        for (int unsigned i = 0; i < FEATURES; i++)
                            feat_q[i] <= bus.in_features[i*FEAT_W +: FEAT_W];
                        node  <= '0;
                        err_q <= 1'b0;
                    end
                end
                EVAL: begin
                    if (malformed) begin
                        cls_q <= '0;
                        err_q <= 1'b1;
                    end else if (present && !overflow) begin
                        node <= child[ADDR_W-1:0];
                    end else begin
                        cls_q <= child[ADDR_W:0];
                        err_q <= present;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef DTREE_TRACE_EN
    logic [ADDR_W:0] path_q;
    logic [ADDR_W:0] depth_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            path_q  <= '0;
            depth_q <= '0;
        end else if (state == IDLE && bus.in_valid) begin
            path_q  <= '0;
            depth_q <= '0;
        end else if (state == EVAL) begin
            depth_q <= depth_q + (ADDR_W+1)'(1);
            if (!malformed) path_q <= path_q | ((ADDR_W+1)'(dir) << depth_q);
        end
    end

    assign bus.out_path  = path_q;
    assign bus.out_depth = depth_q;
`endif
endmodule

// File: tb/tb_dtree_node_evaluator.sv
// Scoreboard bench for dtree_node_evaluator: directed vectors push expectations,
// a negedge monitor pops and compares on each output handshake.
module tb_dtree_node_evaluator;
    logic clk;
    logic reset;
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    typedef struct {
        int          cls;
        int          err;
        int          lat;
        logic [31:0] fsig;
        int          path;
        int          depth;
    } exp_t;

    exp_t        sbq[$];
    logic [23:0] mem [8];

    dtree_node_evaluator_if #(.DEPTH(24), .ADDR_W(3), .FEATURES(3), .FEAT_W(8)) bus ();

    dtree_node_evaluator #(
        .DEPTH(24), .WORDS(8), .FEATURES(3),
        .COEFF_BIT_DEPTH(4), .BIAS_BIT_DEPTH(10), .FEAT_W(8)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (bus.mem_ce) bus.mem_q <= mem[bus.mem_a];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [23:0] mkw(input logic rp, input logic lp, input logic [2:0] oh,
                                        input int c1, input int c0, input int b);
        logic [3:0] a1, a0;
        logic [9:0] bb;
        a1 = c1[3:0];
        a0 = c0[3:0];
        bb = b[9:0];
        return {1'b0, rp, lp, oh, a1, a0, bb};
    endfunction

    function automatic exp_t mk_exp(input int cls, input int err, input int lat,
                                    input logic [31:0] fsig, input int path, input int depth);
        exp_t e;
        e.cls = cls; e.err = err; e.lat = lat; e.fsig = fsig; e.path = path; e.depth = depth;
        return e;
    endfunction

    // Monitor: fetch signature = one byte per mem_ce cycle, {cycle since accept, address}
    int          t_acc = 0;
    int          rel;
    int          lat;
    logic [31:0] fsig = '0;
    logic        seen = 1'b0;
    logic [3:0]  hold_cls;
    logic        hold_err;
    exp_t        e_mon;

    always @(negedge clk) begin
        if (reset) begin
            seen = 1'b0;
        end else begin
            if (bus.in_valid && bus.in_ready) begin
                t_acc = cyc;
                fsig  = '0;
            end
            if (bus.mem_ce) begin
                rel  = cyc - t_acc;
                fsig = (fsig << 8) | 32'((rel & 15) << 4) | 32'(bus.mem_a);
            end
            if (bus.out_valid) begin
                check("busy_in_ready", 32'(bus.in_ready), 32'(0));
                check("busy_mem_ce", 32'(bus.mem_ce), 32'(0));
                if (!seen) begin
                    seen     = 1'b1;
                    lat      = cyc - t_acc;
                    hold_cls = bus.out_class;
                    hold_err = bus.out_err;
                end else begin
                    check("hold_class", 32'(bus.out_class), 32'(hold_cls));
                    check("hold_err", 32'(bus.out_err), 32'(hold_err));
                end
                if (bus.out_ready) begin
                    seen = 1'b0;
                    if (sbq.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_out: got class 0x%0h want no output", bus.out_class);
                    end else begin
                        e_mon = sbq.pop_front();
                        check("out_class", 32'(bus.out_class), 32'(e_mon.cls));
                        check("out_err", 32'(bus.out_err), 32'(e_mon.err));
                        check("latency", 32'(lat), 32'(e_mon.lat));
                        check("fetch_seq", fsig, e_mon.fsig);
                        check("mem_we", 32'(bus.mem_we), 32'(0));
`ifdef DTREE_TRACE_EN
                        check("out_path", 32'(bus.out_path), 32'(e_mon.path));
                        check("out_depth", 32'(bus.out_depth), 32'(e_mon.depth));
`endif
                    end
                end
            end
        end
    end

    // Called at posedge+#1; returns at posedge+#1 just after the accept edge
    task automatic issue(input int f0, input int f1, input int f2, input exp_t e, input bit want);
        int         n;
        logic [7:0] a, b, c;
        a = f0[7:0];
        b = f1[7:0];
        c = f2[7:0];
        bus.in_features = {c, b, a};
        bus.in_valid    = 1'b1;
        n = 0;
        while (!bus.in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.in_ready) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: got in_ready 0 want 1");
        end else if (want) begin
            sbq.push_back(e);
        end
        @(posedge clk); #1;
        bus.in_valid    = 1'b0;
        bus.in_features = ~{c, b, a};
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while ((sbq.size() != 0 || !bus.in_ready) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (sbq.size() != 0 || !bus.in_ready) begin
            total++;
            bad++;
            $display("FAIL done_timeout: got pending %0d want 0", sbq.size());
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 8; i++) mem[i] = '0;
    endtask

    logic [23:0] root_w;
    exp_t        e_t1;
    exp_t        e_h;
    int          n;

    initial begin
        reset           = 1'b1;
        bus.in_valid    = 1'b0;
        bus.in_features = '0;
        bus.out_ready   = 1'b1;
        clear_mem();
        root_w = mkw(1'b1, 1'b1, 3'b001, 0, 1, -5);
        e_t1   = mk_exp(4, 0, 5, 32'h1031, 2, 2);
        e_h    = mk_exp(0, 1, 5, 32'h1032, 1, 2);

        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(bus.in_ready), 32'(0));
        check("rst_mem_ce", 32'(bus.mem_ce), 32'(0));
        check("rst_mem_a", 32'(bus.mem_a), 32'(0));
        check("rst_out_valid", 32'(bus.out_valid), 32'(0));
        check("rst_out_class", 32'(bus.out_class), 32'(0));
        check("rst_out_err", 32'(bus.out_err), 32'(0));
`ifdef DTREE_TRACE_EN
        check("rst_out_depth", 32'(bus.out_depth), 32'(0));
`endif
        reset = 1'b0;
        #1;
        check("post_rst_in_ready", 32'(bus.in_ready), 32'(1));

        // Two-level walk: root left (sum -1), node1 right (sum 1) -> absent slot 4
        mem[0] = root_w;
        mem[1] = mkw(1'b0, 1'b0, 3'b010, 0, 0, 0);
        issue(3, 1, 0, e_t1, 1'b1);
        wait_done();

        // Sign boundary at root, children absent
        clear_mem();
        mem[0] = mkw(1'b0, 1'b0, 3'b001, 0, 0, 0);
        issue(0, 9, -9, mk_exp(2, 0, 3, 32'h10, 1, 1), 1'b1);
        wait_done();
        issue(-1, 9, -9, mk_exp(1, 0, 3, 32'h10, 0, 1), 1'b1);
        wait_done();

        // p=2, extreme coefficients: 127 + 1024 - 896 + bias
        mem[0] = mkw(1'b0, 1'b0, 3'b100, 7, -8, -256);
        issue(-128, -128, 127, mk_exp(1, 0, 3, 32'h10, 0, 1), 1'b1);
        wait_done();
        mem[0] = mkw(1'b0, 1'b0, 3'b100, 7, -8, -255);
        issue(-128, -128, 127, mk_exp(2, 0, 3, 32'h10, 1, 1), 1'b1);
        wait_done();

        // p=1: c0 -> f0, c1 -> f2; 5 + 6 - 6 = 5
        mem[0] = mkw(1'b0, 1'b0, 3'b010, 2, -3, 0);
        issue(-2, 5, -3, mk_exp(2, 0, 3, 32'h10, 1, 1), 1'b1);
        wait_done();

        // Malformed one-hot at root
        mem[0] = mkw(1'b1, 1'b1, 3'b011, 1, 1, 100);
        issue(1, 1, 1, mk_exp(0, 1, 3, 32'h10, 0, 1), 1'b1);
        wait_done();

        // Root right to node2 with zero one-hot
        clear_mem();
        mem[0] = root_w;
        issue(5, 1, 0, e_h, 1'b1);
        wait_done();

        // Overflow: 0 -> 1 -> 4 -> child 10 present
        mem[1] = mkw(1'b1, 1'b0, 3'b010, 0, 0, 0);
        mem[4] = mkw(1'b1, 1'b0, 3'b001, 0, 0, 0);
        issue(3, 1, 0, mk_exp(10, 1, 7, 32'h103154, 6, 3), 1'b1);
        wait_done();
        mem[4] = mkw(1'b0, 1'b0, 3'b001, 0, 0, 0);
        issue(3, 1, 0, mk_exp(10, 0, 7, 32'h103154, 6, 3), 1'b1);
        wait_done();

        // Backpressure
        clear_mem();
        mem[0] = root_w;
        mem[1] = mkw(1'b0, 1'b0, 3'b010, 0, 0, 0);
        bus.out_ready = 1'b0;
        issue(3, 1, 0, e_t1, 1'b1);
        n = 0;
        while (!bus.out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("bp_valid_seen", 32'(bus.out_valid), 32'(1));
        repeat (10) begin
            @(posedge clk); #1;
            check("bp_hold_valid", 32'(bus.out_valid), 32'(1));
            check("bp_hold_class", 32'(bus.out_class), 32'(4));
            check("bp_in_ready", 32'(bus.in_ready), 32'(0));
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_in_ready_after", 32'(bus.in_ready), 32'(1));
        check("bp_valid_after", 32'(bus.out_valid), 32'(0));
        issue(5, 1, 0, e_h, 1'b1);
        wait_done();

        // Reset while in EVAL, then a normal vector
        issue(3, 1, 0, e_t1, 1'b0);
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        check("midrst_in_ready", 32'(bus.in_ready), 32'(0));
        check("midrst_mem_ce", 32'(bus.mem_ce), 32'(0));
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        check("midrst_idle_ce", 32'(bus.mem_ce), 32'(0));
        check("midrst_idle_valid", 32'(bus.out_valid), 32'(0));
        check("midrst_idle_ready", 32'(bus.in_ready), 32'(1));
        issue(3, 1, 0, e_t1, 1'b1);
        wait_done();

        if (sbq.size() != 0) begin
            total++;
            bad++;
            $display("FAIL leftover_expect: got %0d want 0", sbq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
